// File: rtl/instr_encode_loader.sv
// Packs decoded MIPS fields into 32-bit words, buffers them in a FIFO and streams them
// into instruction memory. Define INSTR_ENC_CHECK_EN to add format/opcode consistency checks.
module instr_encode_loader #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              last_i,
  input  logic [1:0]        fmt_i,
  input  logic [5:0]        op_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        shamt_i,
  input  logic [5:0]        funct_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       target_i,
  input  logic              mem_ready_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic [ADDR_W-2:0] count_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE      = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ADDR_STEP = 4;
  localparam logic [ADDR_W-2:0] CNT_ONE   = 1;
  localparam logic [PTR_W:0]    PTR_ONE   = 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_fifo [DEPTH];
  logic [PTR_W:0]     r_wptr;
  logic [PTR_W:0]     r_rptr;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-2:0]  r_count;
  logic               r_err;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [31:0]        r_wr_data;

  logic               w_empty;
  logic               w_full;
  logic               w_ready;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_word;
  logic               w_bad;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_push  = valid_i && w_ready;
  assign w_pop   = ((r_state == S_LOAD) || (r_state == S_DRAIN)) && !w_empty && mem_ready_i;

  always_comb begin
    w_word = '0;
    w_bad  = 1'b0;
    case (fmt_i)
      2'd0:    w_word = {op_i, rs_i, rt_i, rd_i, shamt_i, funct_i};
      2'd1:    w_word = {op_i, rs_i, rt_i, imm_i};
      2'd2:    w_word = {op_i, target_i};
      default: w_bad  = 1'b1;
    endcase
`ifdef INSTR_ENC_CHECK_EN
    case (fmt_i)
      2'd0:    if (op_i != 6'd0) w_bad = 1'b1;
      2'd1:    if ((op_i == 6'd0) || (op_i == 6'd2) || (op_i == 6'd3)) w_bad = 1'b1;
      2'd2:    if ((op_i != 6'd2) && (op_i != 6'd3)) w_bad = 1'b1;
      default: w_bad = 1'b1;
    endcase
`endif
    if (w_bad) w_word = '0;
  end

  // DRAIN waits for the last registered write to leave before reporting completion.
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    done_o  = 1'b0;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_LOAD;
      S_LOAD: begin
        w_ready = !w_full;
        if (valid_i && !w_full && last_i) w_next = S_DRAIN;
      end
      S_DRAIN: if (w_empty && !r_wr_en) w_next = S_DONE;
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr[PTR_W-1:0]] <= w_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_addr    <= BASE;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_next;
      r_wr_en <= w_pop;
      if ((r_state == S_IDLE) && start_i) begin
        r_addr  <= BASE;
        r_count <= '0;
        r_err   <= 1'b0;
      end
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
        if (w_bad) r_err <= 1'b1;
      end
      if (w_pop) begin
        r_rptr    <= r_rptr + PTR_ONE;
        r_wr_addr <= r_addr;
        r_wr_data <= r_fifo[r_rptr[PTR_W-1:0]];
        r_addr    <= r_addr + ADDR_STEP;
        r_count   <= r_count + CNT_ONE;
      end
    end
  end

  assign ready_o   = w_ready;
  assign wr_en_o   = r_wr_en;
  assign wr_addr_o = r_wr_addr;
  assign wr_data_o = r_wr_data;
  assign count_o   = r_count;
  assign err_o     = r_err;

endmodule
